// File: rtl/adv_video_pkg.sv
// Shared video timing defaults, colour constants and test-pattern encodings.
package adv_video_pkg;
    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;
    localparam logic        DEF_HS_POL   = 1'b1;
    localparam logic        DEF_VS_POL   = 1'b1;

    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;

    localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] C_CYAN    = 24'h00FFFF;
    localparam logic [23:0] C_GREEN   = 24'h00FF00;
    localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] C_RED     = 24'hFF0000;
    localparam logic [23:0] C_BLUE    = 24'h0000FF;
    localparam logic [23:0] C_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BLACK = 2'd3
    } pat_e;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction
endpackage

// File: rtl/adv_timing_gen_if.sv
// Pixel request / video output bundle between the timing generator and its source and sink.
interface adv_timing_gen_if;
    import adv_video_pkg::*;

    logic [1:0]    pattern_sel;
    logic          pix_req;
    logic [HW-1:0] pix_x;
    logic [VW-1:0] pix_y;
    logic [23:0]   pix_data;
    logic          videoblank;
    logic          hsync;
    logic          vsync;
    logic [23:0]   data;
    logic          frame_start;

    modport master (
        input  pattern_sel, pix_data,
        output pix_req, pix_x, pix_y, videoblank, hsync, vsync, data, frame_start
    );

    modport slave (
        output pattern_sel, pix_data,
        input  pix_req, pix_x, pix_y, videoblank, hsync, vsync, data, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Internal test patterns (colour bars, 16x16 checker, black); one register stage aligned to stage 1.
module video_pattern_gen
    import adv_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic          clk_pixel,
    input  logic          reset,
    input  logic [HW-1:0] h_i,
    input  logic [VW-1:0] v_i,
    input  pat_e          pat_i,
    output logic [23:0]   colour_o,
    output logic          use_ext_o
);
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);

    logic [HW-1:0] sub_q, sub_d, sub_cur;
    logic [2:0]    idx_q, idx_d, idx_cur;
    logic [23:0]   colour_q, colour_d;
    logic          use_ext_q;

    // Bar position restarts at h=0 so stray counts from the blanking interval never leak in.
    always_comb begin
        sub_cur = (h_i == '0) ? '0 : sub_q;
        idx_cur = (h_i == '0) ? '0 : idx_q;
        sub_d   = (sub_cur == BAR_LAST) ? '0 : sub_cur + HW'(1);
        idx_d   = (sub_cur == BAR_LAST) ? idx_cur + 3'd1 : idx_cur;
        case (pat_i)
            PAT_BARS:  colour_d = bar_colour(idx_cur);
            PAT_CHECK: colour_d = (h_i[4] ^ v_i[4]) ? C_WHITE : C_BLACK;
            default:   colour_d = C_BLACK;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            sub_q     <= '0;
            idx_q     <= '0;
            colour_q  <= '0;
            use_ext_q <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            idx_q     <= idx_d;
            colour_q  <= colour_d;
            use_ext_q <= (pat_i == PAT_EXT);
        end
    end

    assign colour_o  = colour_q;
    assign use_ext_o = use_ext_q;
endmodule

// File: rtl/adv_timing_gen.sv
// Video timing generator: H/V counters, sync/blank decode and a two-stage output pipeline.
module adv_timing_gen
    import adv_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = DEF_HS_POL,
    parameter logic        VS_POL   = DEF_VS_POL
) (
    input  logic              clk_pixel,
    input  logic              reset,
    adv_timing_gen_if.master  vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          act0, hs0, vs0, sof0;
    logic          act1_q, hs1_q, vs1_q, sof1_q;
    logic          pix_req_q;
    logic [HW-1:0] pix_x_q;
    logic [VW-1:0] pix_y_q;
    logic          blank_q, hsync_q, vsync_q, fs_q;
    logic [23:0]   data_q;
    pat_e          pat_q, pat_eff;
    logic [23:0]   pat_colour;
    logic          pat_ext;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
        act0 = (h_q < H_ACT) && (v_q < V_ACT);
        hs0  = (h_q >= HS_BEG) && (h_q < HS_END);
        vs0  = (v_q >= VS_BEG) && (v_q < VS_END);
        sof0 = (h_q == '0) && (v_q == '0);
        // The frame's first pixel must already see the newly sampled pattern.
        pat_eff = sof0 ? pat_e'(vid.pattern_sel) : pat_q;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            pat_q     <= PAT_EXT;
            act1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            sof1_q    <= 1'b0;
            pix_req_q <= 1'b0;
            blank_q   <= 1'b1;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            data_q    <= '0;
            fs_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            pat_q     <= pat_eff;
            act1_q    <= act0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
            sof1_q    <= sof0;
            pix_req_q <= act0;
            blank_q   <= ~act1_q;
            hsync_q   <= hs1_q ? HS_POL : ~HS_POL;
            vsync_q   <= vs1_q ? VS_POL : ~VS_POL;
            data_q    <= act1_q ? (pat_ext ? vid.pix_data : pat_colour) : '0;
            fs_q      <= sof1_q;
        end
    end

    // Request coordinates simply hold while reset is asserted.
    always_ff @(posedge clk_pixel) begin
        if (!reset) begin
            pix_x_q <= h_q;
            pix_y_q <= v_q;
        end
    end

    video_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .h_i       (h_q),
        .v_i       (v_q),
        .pat_i     (pat_eff),
        .colour_o  (pat_colour),
        .use_ext_o (pat_ext)
    );

    assign vid.pix_req     = pix_req_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.videoblank  = blank_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.data        = data_q;
    assign vid.frame_start = fs_q;
endmodule

// File: tb/tb_adv_timing_gen.sv
// Bench for adv_timing_gen: reduced-timing instance against a frame-arithmetic model, default instance pinned by literals.
module tb_adv_timing_gen;
    import adv_video_pkg::*;

    localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 20, VFP = 1, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adv_timing_gen_if vs_if ();
    adv_timing_gen_if vd_if ();

    adv_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut_s (
        .clk_pixel (clk),
        .reset     (rst),
        .vid       (vs_if.master)
    );

    adv_timing_gen dut_d (
        .clk_pixel (clk),
        .reset     (rst),
        .vid       (vd_if.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int k = 0;
    int pats[int];
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, req);
        end
    endtask

    task automatic check_small();
        int s, h, v, cur_pat;
        logic act, hs, vsy, sof;
        logic [23:0] d;
        if (k >= 1) begin
            s = k - 1;
            h = s % HT;
            v = (s / HT) % VT;
            act = (h < HA) && (v < VA);
            chk("pix_req", vs_if.pix_req, act);
            if (act) begin
                chk("pix_x", vs_if.pix_x, h);
                chk("pix_y", vs_if.pix_y, v);
            end
        end else begin
            chk("pix_req_rst", vs_if.pix_req, 0);
        end
        if (k < 2) begin
            chk("blank_rst", vs_if.videoblank, 1);
            chk("hsync_rst", vs_if.hsync, 1);
            chk("vsync_rst", vs_if.vsync, 0);
            chk("data_rst", vs_if.data, 0);
            chk("fs_rst", vs_if.frame_start, 0);
            return;
        end
        s = k - 2;
        h = s % HT;
        v = (s / HT) % VT;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HSY);
        vsy = (v >= VA + VFP) && (v < VA + VFP + VSY);
        sof = (s % FT) == 0;
        cur_pat = pats.exists(s / FT) ? pats[s / FT] : 0;
        if (!act)              d = 24'h0;
        else if (cur_pat == 0) d = 24'((v << 9) | (h & 511));
        else if (cur_pat == 1) d = bars[h / (HA / 8)];
        else if (cur_pat == 2) d = ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        else                   d = 24'h0;
        chk("videoblank", vs_if.videoblank, !act);
        chk("hsync", vs_if.hsync, !hs);
        chk("vsync", vs_if.vsync, vsy);
        chk("frame_start", vs_if.frame_start, sof);
        chk("data", vs_if.data, d);
        // Literal pins on the model
        if (k == 2)                              chk("pin_fs_edge2", vs_if.frame_start, 1);
        if (k == 2 + FT)                         chk("pin_fs_period", vs_if.frame_start, 1);
        if (cur_pat == 0 && s % FT == 3 * HT + 5) chk("pin_ext_x5y3", vs_if.data, 24'h000605);
        if (cur_pat == 1 && v == 0) begin
            if (h == 0)  chk("pin_bar_x0", vs_if.data, 24'hFFFFFF);
            if (h == 4)  chk("pin_bar_x4", vs_if.data, 24'hFFFF00);
            if (h == 31) chk("pin_bar_x31", vs_if.data, 24'h000000);
        end
        if (cur_pat == 2 && v == 0 && h == 16) chk("pin_chk_16_0", vs_if.data, 24'hFFFFFF);
        if (cur_pat == 2 && v == 0 && h == 0)  chk("pin_chk_0_0", vs_if.data, 24'h000000);
    endtask

    task automatic check_dflt();
        if (k == 0)    chk("d_blank_rst", vd_if.videoblank, 1);
        if (k == 1)    chk("d_fs_edge1", vd_if.frame_start, 0);
        if (k == 2)    chk("d_fs_edge2", vd_if.frame_start, 1);
        if (k == 2)    chk("d_blank_edge2", vd_if.videoblank, 0);
        if (k == 3)    chk("d_fs_edge3", vd_if.frame_start, 0);
        if (k == 801)  chk("d_blank_edge801", vd_if.videoblank, 0);
        if (k == 802)  chk("d_blank_edge802", vd_if.videoblank, 1);
        if (k == 841)  chk("d_hsync_edge841", vd_if.hsync, 0);
        if (k == 842)  chk("d_hsync_edge842", vd_if.hsync, 1);
        if (k == 969)  chk("d_hsync_edge969", vd_if.hsync, 1);
        if (k == 970)  chk("d_hsync_edge970", vd_if.hsync, 0);
        if (k == 1057) chk("d_blank_edge1057", vd_if.videoblank, 1);
        if (k == 1058) chk("d_blank_edge1058", vd_if.videoblank, 0);
        if (k == 1058) chk("d_vsync_line1", vd_if.vsync, 0);
    endtask

    initial begin
        logic rst_s;
        int   ps_s;
        forever begin
            @(posedge clk);
            rst_s = rst;
            ps_s  = int'(vs_if.pattern_sel);
            if (rst_s) begin
                k = 0;
                pats.delete();
            end else begin
                k++;
                if ((k - 1) % FT == 0) pats[(k - 1) / FT] = ps_s;
            end
            #1;
            check_small();
            check_dflt();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            vs_if.pix_data = vs_if.pix_req ? {5'b0, vs_if.pix_y, vs_if.pix_x[8:0]} : 24'($urandom);
        end
    end

    initial begin
        vs_if.pattern_sel = 2'd0;
        vd_if.pattern_sel = 2'd0;
        vd_if.pix_data    = 24'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FT + 100) @(negedge clk);
        vs_if.pattern_sel = 2'd1;
        repeat (FT) @(negedge clk);
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(1, FT - 1)) @(negedge clk);
            vs_if.pattern_sel = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 2 * FT && (k % FT) != 10 * HT + 7; i++) @(negedge clk);
        vs_if.pattern_sel = 2'd2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FT) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
